// File: rtl/video_pkg.sv
// video_pkg: shared raster constants, sync polarity encoding, counter width
// helpers and pixel repeat factor for the video fetch block.
// Optional build macro: VIDEO_SCANDOUBLE_EN (each source pixel/line shown twice).
package video_pkg;

    // Default 640x480@60 raster
    localparam int unsigned H_ACTIVE_DEF = 640;
    localparam int unsigned H_FP_DEF     = 16;
    localparam int unsigned H_SYNC_DEF   = 96;
    localparam int unsigned H_BP_DEF     = 48;
    localparam int unsigned V_ACTIVE_DEF = 480;
    localparam int unsigned V_FP_DEF     = 10;
    localparam int unsigned V_SYNC_DEF   = 2;
    localparam int unsigned V_BP_DEF     = 33;

    localparam int unsigned H_TOTAL_DEF = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
    localparam int unsigned V_TOTAL_DEF = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

    // Level driven on hsync/vsync while the sync interval is asserted
    typedef enum logic {
        SYNC_ACTIVE_LOW  = 1'b0,
        SYNC_ACTIVE_HIGH = 1'b1
    } sync_pol_e;

    function automatic int unsigned counter_width(input int unsigned total);
        return (total < 2) ? 1 : $clog2(total);
    endfunction

    localparam int unsigned HCOUNT_W = counter_width(H_TOTAL_DEF);
    localparam int unsigned VCOUNT_W = counter_width(V_TOTAL_DEF);

    // Raster position at the default timing
    typedef struct packed {
        logic [VCOUNT_W-1:0] vcount;
        logic [HCOUNT_W-1:0] hcount;
    } raster_pos_t;

`ifdef VIDEO_SCANDOUBLE_EN
    localparam int unsigned PIX_REP = 2;
`else
    localparam int unsigned PIX_REP = 1;
`endif

    // Clocks between consecutive byte fetches within a line
    localparam int unsigned FETCH_PERIOD = 8 * PIX_REP;

endpackage

// File: rtl/video_timing.sv
// video_timing: H/V raster counters, sync/blank decode and fetch strobes.
// Optional build macro: VIDEO_SCANDOUBLE_EN (via video_pkg::PIX_REP).
module video_timing
    import video_pkg::*;
#(
    parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
    parameter int unsigned H_FP     = H_FP_DEF,
    parameter int unsigned H_SYNC   = H_SYNC_DEF,
    parameter int unsigned H_BP     = H_BP_DEF,
    parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
    parameter int unsigned V_FP     = V_FP_DEF,
    parameter int unsigned V_SYNC   = V_SYNC_DEF,
    parameter int unsigned V_BP     = V_BP_DEF,
    parameter bit          SYNC_POL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    output logic hsync,
    output logic vsync,
    output logic active,
    output logic frame_start,
    output logic fetch_strobe,
    output logic fetch_first,
    output logic frame_load,
    output logic line_reload,
    output logic shift_en
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HW      = counter_width(H_TOTAL);
    localparam int unsigned VW      = counter_width(V_TOTAL);
    localparam int unsigned HS_BEG  = H_ACTIVE + H_FP;
    localparam int unsigned HS_END  = HS_BEG + H_SYNC;
    localparam int unsigned VS_BEG  = V_ACTIVE + V_FP;
    localparam int unsigned VS_END  = VS_BEG + V_SYNC;

    logic [HW-1:0] hcount;
    logic [VW-1:0] vcount;
    logic          h_last;
    logic          v_last;
    logic          h_wrap_ahead;
    logic [HW-1:0] h_ahead;
    logic [VW-1:0] v_ahead;

    // Raster counters; reset parks on the cycle that prefetches line 0 byte 0
    always_ff @(posedge clk) begin
        if (reset) begin
            hcount <= HW'(H_TOTAL - 2);
            vcount <= VW'(V_TOTAL - 1);
        end else if (h_last) begin
            hcount <= '0;
            vcount <= v_last ? '0 : vcount + VW'(1);
        end else begin
            hcount <= hcount + HW'(1);
        end
    end

    // Decode outputs and fetch strobes from the current raster position
    always_comb begin
        h_last       = (hcount == HW'(H_TOTAL - 1));
        v_last       = (vcount == VW'(V_TOTAL - 1));
        // A fetch at hcount targets the pixel two clocks later, possibly on the next line
        h_wrap_ahead = (hcount >= HW'(H_TOTAL - 2));
        h_ahead      = h_wrap_ahead ? hcount - HW'(H_TOTAL - 2) : hcount + HW'(2);
        v_ahead      = vcount;
        if (h_wrap_ahead) begin
            v_ahead = v_last ? '0 : vcount + VW'(1);
        end

        active       = (hcount < HW'(H_ACTIVE)) && (vcount < VW'(V_ACTIVE));
        hsync        = ((hcount >= HW'(HS_BEG)) && (hcount < HW'(HS_END))) ? SYNC_POL : ~SYNC_POL;
        vsync        = ((vcount >= VW'(VS_BEG)) && (vcount < VW'(VS_END))) ? SYNC_POL : ~SYNC_POL;
        frame_start  = (hcount == '0) && (vcount == '0);

        fetch_strobe = (h_ahead < HW'(H_ACTIVE))
                    && ((h_ahead & HW'(FETCH_PERIOD - 1)) == '0)
                    && (v_ahead < VW'(V_ACTIVE));
        fetch_first  = (h_ahead == '0);
        frame_load   = (hcount == '0) && v_last;
        // Even display lines rewind the pointer so the odd line repeats the same source line
        line_reload  = (PIX_REP > 1) && (hcount == HW'(H_ACTIVE))
                    && (vcount < VW'(V_ACTIVE)) && !vcount[0];
        shift_en     = (PIX_REP == 1) || hcount[0];
    end

endmodule

// File: rtl/video_fetch.sv
// video_fetch: framebuffer reader driving the memory video port and a 1bpp
// MSB-first pixel stream with VGA-style sync and blanking.
// Optional build macro: VIDEO_SCANDOUBLE_EN (2x pixel and line replication).
module video_fetch
    import video_pkg::*;
#(
    parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
    parameter int unsigned H_FP     = H_FP_DEF,
    parameter int unsigned H_SYNC   = H_SYNC_DEF,
    parameter int unsigned H_BP     = H_BP_DEF,
    parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
    parameter int unsigned V_FP     = V_FP_DEF,
    parameter int unsigned V_SYNC   = V_SYNC_DEF,
    parameter int unsigned V_BP     = V_BP_DEF,
    parameter bit          SYNC_POL = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] base_addr,
    output logic        mem_en,
    output logic [15:0] mem_addr,
    input  logic [7:0]  mem_data,
    output logic        hsync,
    output logic        vsync,
    output logic        active,
    output logic        pixel,
    output logic        frame_start
);

    logic        fetch_strobe;
    logic        fetch_first;
    logic        frame_load;
    logic        line_reload;
    logic        shift_en;
    logic [15:0] fetch_ptr;
    logic [15:0] line_start;
    logic [7:0]  shreg;
    logic        mem_en_d;

    video_timing #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP),
        .SYNC_POL (SYNC_POL)
    ) u_timing (
        .clk          (clk),
        .reset        (reset),
        .hsync        (hsync),
        .vsync        (vsync),
        .active       (active),
        .frame_start  (frame_start),
        .fetch_strobe (fetch_strobe),
        .fetch_first  (fetch_first),
        .frame_load   (frame_load),
        .line_reload  (line_reload),
        .shift_en     (shift_en)
    );

    // Held off during reset so the parked prefetch position issues no read
    assign mem_en   = fetch_strobe & ~reset;
    assign mem_addr = fetch_ptr;
    assign pixel    = active & shreg[7];

    // Framebuffer pointer: frame-boundary base load, line rewind, post-increment per fetch
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_ptr  <= base_addr;
            line_start <= base_addr;
        end else if (frame_load) begin
            fetch_ptr  <= base_addr;
            line_start <= base_addr;
        end else if (line_reload) begin
            fetch_ptr  <= line_start;
        end else if (fetch_strobe) begin
            fetch_ptr  <= fetch_ptr + 16'd1;
            if (fetch_first) begin
                line_start <= fetch_ptr;
            end
        end
    end

    // Pixel shifter: capture read data one cycle after the request, else shift out MSB-first
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_en_d <= 1'b0;
            shreg    <= '0;
        end else begin
            mem_en_d <= fetch_strobe;
            if (mem_en_d) begin
                shreg <= mem_data;
            end else if (shift_en) begin
                shreg <= {shreg[6:0], 1'b0};
            end
        end
    end

endmodule

// File: tb/tb_video_fetch.sv
// tb_video_fetch: directed self-checking bench for video_fetch on a reduced
// 64x6 raster (96x10 total) with a one-cycle-latency byte memory model.
// Optional build macro: VIDEO_SCANDOUBLE_EN (selects 2x expectations).
module tb_video_fetch;

    localparam int unsigned HA = 64;
    localparam int unsigned HFP = 8;
    localparam int unsigned HS = 16;
    localparam int unsigned HB = 8;
    localparam int unsigned HT = HA + HFP + HS + HB;
    localparam int unsigned VA = 6;
    localparam int unsigned VFP = 1;
    localparam int unsigned VS = 2;
    localparam int unsigned VB = 1;
    localparam int unsigned VT = VA + VFP + VS + VB;
`ifdef VIDEO_SCANDOUBLE_EN
    localparam int unsigned REP = 2;
`else
    localparam int unsigned REP = 1;
`endif
    localparam int unsigned STRIDE = HA / (8 * REP);

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] base_addr = 16'h0000;
    logic        mem_en;
    logic [15:0] mem_addr;
    logic [7:0]  mem_data;
    logic        hsync;
    logic        vsync;
    logic        active;
    logic        pixel;
    logic        frame_start;

    logic [7:0]  mem [0:65535];
    logic [7:0]  rdata = 8'h00;
    int          th = 0;
    int          tv = 0;
    int          errors = 0;
    int          checks = 0;

    video_fetch #(
        .H_ACTIVE (HA), .H_FP (HFP), .H_SYNC (HS), .H_BP (HB),
        .V_ACTIVE (VA), .V_FP (VFP), .V_SYNC (VS), .V_BP (VB),
        .SYNC_POL (1'b0)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .base_addr   (base_addr),
        .mem_en      (mem_en),
        .mem_addr    (mem_addr),
        .mem_data    (mem_data),
        .hsync       (hsync),
        .vsync       (vsync),
        .active      (active),
        .pixel       (pixel),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    // Memory video port: one-cycle synchronous read
    always @(posedge clk) begin
        if (mem_en) rdata <= mem[mem_addr];
    end
    assign mem_data = rdata;

    // Reference raster position
    always @(posedge clk) begin
        if (reset) begin
            th <= HT - 2;
            tv <= VT - 1;
        end else if (th == HT - 1) begin
            th <= 0;
            tv <= (tv == VT - 1) ? 0 : tv + 1;
        end else begin
            th <= th + 1;
        end
    end

    function automatic logic exp_pix(input int h, input int v, input logic [15:0] fb);
        logic [15:0] a;
        logic [7:0]  b;
        int          col;
        if (!(h < HA && v < VA)) return 1'b0;
        col = h / REP;
        a = fb + 16'((v / REP) * STRIDE + col / 8);
        b = mem[a];
        return b[7 - (col % 8)];
    endfunction

    function automatic int tgt_line(input int h, input int v);
        return (h >= HT - 2) ? (v + 1) % VT : v;
    endfunction

    function automatic logic exp_en(input int h, input int v);
        int h2;
        h2 = (h + 2) % HT;
        return (h2 < HA) && (h2 % (8 * REP) == 0) && (tgt_line(h, v) < VA);
    endfunction

    function automatic logic [15:0] exp_addr(input int h, input int v, input logic [15:0] fb);
        int h2;
        h2 = (h + 2) % HT;
        return fb + 16'((tgt_line(h, v) / REP) * STRIDE + h2 / (8 * REP));
    endfunction

    function automatic logic exp_hsync(input int h);
        return (h >= HA + HFP && h < HA + HFP + HS) ? 1'b0 : 1'b1;
    endfunction

    function automatic logic exp_vsync(input int v);
        return (v >= VA + VFP && v < VA + VFP + VS) ? 1'b0 : 1'b1;
    endfunction

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic apply_reset(input logic [15:0] b);
        @(negedge clk);
        reset = 1'b1;
        base_addr = b;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1;
        base_addr = 16'h1000;
        repeat (3) @(negedge clk);
        #1;
        checks++; if (mem_en !== 1'b0) begin errors++; $display("FAIL reset_mem_en: got %b expected 0", mem_en); end
        checks++; if (hsync !== 1'b1) begin errors++; $display("FAIL reset_hsync: got %b expected 1", hsync); end
        checks++; if (vsync !== 1'b1) begin errors++; $display("FAIL reset_vsync: got %b expected 1", vsync); end
        checks++; if (active !== 1'b0) begin errors++; $display("FAIL reset_active: got %b expected 0", active); end
        checks++; if (pixel !== 1'b0) begin errors++; $display("FAIL reset_pixel: got %b expected 0", pixel); end
        checks++; if (frame_start !== 1'b0) begin errors++; $display("FAIL reset_frame_start: got %b expected 0", frame_start); end
        checks++; if (mem_addr !== 16'h1000) begin errors++; $display("FAIL reset_mem_addr: got %h expected 1000", mem_addr); end
        reset = 1'b0;
        #1;
        checks++; if (mem_en !== 1'b1) begin errors++; $display("FAIL first_fetch_en: got %b expected 1", mem_en); end
        checks++; if (mem_addr !== 16'h1000) begin errors++; $display("FAIL first_fetch_addr: got %h expected 1000", mem_addr); end
    endtask

    task automatic test_raster();
        logic prev_h = 1'b1;
        logic prev_v = 1'b1;
        int   last_hf = -1;
        int   last_vf = -1;
        int   last_fs = -1;
        int   hfalls = 0;
        int   vfalls = 0;
        int   nfs = 0;
        for (int c = 0; c < 2 * HT * VT; c++) begin
            checks++; if (hsync !== exp_hsync(th)) begin errors++; $display("FAIL raster_hsync h=%0d v=%0d: got %b expected %b", th, tv, hsync, exp_hsync(th)); end
            checks++; if (vsync !== exp_vsync(tv)) begin errors++; $display("FAIL raster_vsync h=%0d v=%0d: got %b expected %b", th, tv, vsync, exp_vsync(tv)); end
            checks++; if (active !== (th < HA && tv < VA)) begin errors++; $display("FAIL raster_active h=%0d v=%0d: got %b", th, tv, active); end
            checks++; if (frame_start !== (th == 0 && tv == 0)) begin errors++; $display("FAIL raster_frame_start h=%0d v=%0d: got %b", th, tv, frame_start); end
            checks++; if (pixel !== exp_pix(th, tv, 16'h1000)) begin errors++; $display("FAIL raster_pixel h=%0d v=%0d: got %b expected %b", th, tv, pixel, exp_pix(th, tv, 16'h1000)); end
            checks++; if (mem_en !== exp_en(th, tv)) begin errors++; $display("FAIL raster_mem_en h=%0d v=%0d: got %b expected %b", th, tv, mem_en, exp_en(th, tv)); end
            if (exp_en(th, tv)) begin
                checks++; if (mem_addr !== exp_addr(th, tv, 16'h1000)) begin errors++; $display("FAIL raster_mem_addr h=%0d v=%0d: got %h expected %h", th, tv, mem_addr, exp_addr(th, tv, 16'h1000)); end
            end
            if (th == HT - 2 && tv == 0) begin
                checks++; if (mem_en !== 1'b1 || mem_addr !== 16'(16'h1000 + STRIDE)) begin errors++; $display("FAIL line1_first_fetch: got en=%b addr=%h expected en=1 addr=%h", mem_en, mem_addr, 16'(16'h1000 + STRIDE)); end
            end
            if (prev_h && !hsync) begin
                hfalls++;
                if (last_hf >= 0) begin
                    checks++; if (c - last_hf != HT) begin errors++; $display("FAIL hsync_period: got %0d expected %0d", c - last_hf, HT); end
                end
                last_hf = c;
            end
            if (!prev_h && hsync && last_hf >= 0) begin
                checks++; if (c - last_hf != HS) begin errors++; $display("FAIL hsync_width: got %0d expected %0d", c - last_hf, HS); end
            end
            if (prev_v && !vsync) begin
                vfalls++;
                if (last_vf >= 0) begin
                    checks++; if (c - last_vf != HT * VT) begin errors++; $display("FAIL vsync_period: got %0d expected %0d", c - last_vf, HT * VT); end
                end
                last_vf = c;
            end
            if (!prev_v && vsync && last_vf >= 0) begin
                checks++; if (c - last_vf != VS * HT) begin errors++; $display("FAIL vsync_width: got %0d expected %0d", c - last_vf, VS * HT); end
            end
            if (frame_start) begin
                nfs++;
                if (last_fs >= 0) begin
                    checks++; if (c - last_fs != HT * VT) begin errors++; $display("FAIL frame_start_period: got %0d expected %0d", c - last_fs, HT * VT); end
                end
                last_fs = c;
            end
            prev_h = hsync;
            prev_v = vsync;
            step();
        end
        checks++; if (hfalls != 20) begin errors++; $display("FAIL hsync_pulse_count: got %0d expected 20", hfalls); end
        checks++; if (vfalls != 2) begin errors++; $display("FAIL vsync_pulse_count: got %0d expected 2", vfalls); end
        checks++; if (nfs != 2) begin errors++; $display("FAIL frame_start_count: got %0d expected 2", nfs); end
    endtask

`ifdef VIDEO_SCANDOUBLE_EN
    task automatic test_scandouble();
        int n = 0;
        int l1n = 0;
        int k;
        int tl;
        mem[16'h1000] = 8'h80;
        apply_reset(16'h1000);
        step();
        step();
        for (int i = 0; i < 16; i++) begin
            checks++; if (pixel !== (i < 2)) begin errors++; $display("FAIL sd_pixel h=%0d: got %b expected %b", th, pixel, (i < 2)); end
            step();
        end
        while (!(tv == 2 && th == HA) && n < 4 * HT) begin
            if (mem_en) begin
                tl = tgt_line(th, tv);
                k = ((th + 2) % HT) / 16;
                if (tl == 1) l1n++;
                checks++;
                if (tl <= 1 && mem_addr !== 16'(16'h1000 + k)) begin errors++; $display("FAIL sd_line%0d_addr k=%0d: got %h expected %h", tl, k, mem_addr, 16'(16'h1000 + k)); end
                else if (tl == 2 && mem_addr !== 16'(16'h1004 + k)) begin errors++; $display("FAIL sd_line2_addr k=%0d: got %h expected %h", k, mem_addr, 16'(16'h1004 + k)); end
            end
            step();
            n++;
        end
        checks++; if (!(tv == 2 && th == HA)) begin errors++; $display("FAIL sd_timeout: got h=%0d v=%0d expected h=%0d v=2", th, tv, HA); end
        checks++; if (l1n != 4) begin errors++; $display("FAIL sd_line1_fetches: got %0d expected 4", l1n); end
        mem[16'h1000] = 8'h00;
    endtask
`else
    task automatic test_a5();
        logic [7:0] pat = 8'hA5;
        int n = 0;
        mem[16'h1000] = 8'hA5;
        apply_reset(16'h1000);
        step();
        step();
        for (int i = 0; i < 8; i++) begin
            checks++; if (pixel !== pat[7 - i]) begin errors++; $display("FAIL a5_pixel h=%0d: got %b expected %b", i, pixel, pat[7 - i]); end
            step();
        end
        while (th != HA && n < 2 * HT) begin step(); n++; end
        checks++; if (th != HA) begin errors++; $display("FAIL a5_timeout: got h=%0d expected %0d", th, HA); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (pixel !== 1'b0 || active !== 1'b0) begin errors++; $display("FAIL blank_pixel h=%0d: got pixel=%b active=%b expected 0 0", th, pixel, active); end
            step();
        end
        mem[16'h1000] = 8'h00;
    endtask
`endif

    task automatic test_wrap();
        logic [15:0] w = 16'h0000 - 16'(STRIDE / 2);
        int idx = 0;
        int n = 0;
        logic saw_ffff = 1'b0;
        logic saw_0000 = 1'b0;
        apply_reset(w);
        while (!(tv == 0 && th == HA) && n < 3 * HT) begin
            if (mem_en) begin
                checks++; if (mem_addr !== 16'(w + idx)) begin errors++; $display("FAIL wrap_addr idx=%0d: got %h expected %h", idx, mem_addr, 16'(w + idx)); end
                if (mem_addr === 16'hFFFF) saw_ffff = 1'b1;
                if (mem_addr === 16'h0000) saw_0000 = 1'b1;
                idx++;
            end
            if (tv == 0) begin
                checks++; if (pixel !== exp_pix(th, 0, w)) begin errors++; $display("FAIL wrap_pixel h=%0d: got %b expected %b", th, pixel, exp_pix(th, 0, w)); end
            end
            step();
            n++;
        end
        checks++; if (!(tv == 0 && th == HA)) begin errors++; $display("FAIL wrap_timeout: got h=%0d v=%0d", th, tv); end
        checks++; if (idx != STRIDE) begin errors++; $display("FAIL wrap_fetch_count: got %0d expected %0d", idx, STRIDE); end
        checks++; if (!(saw_ffff && saw_0000)) begin errors++; $display("FAIL wrap_crossing: got ffff=%b 0000=%b expected 1 1", saw_ffff, saw_0000); end
    endtask

    task automatic test_base_change();
        int n = 0;
        apply_reset(16'h1000);
        while (!(tv == 2 && th == 10) && n < 4 * HT) begin step(); n++; end
        checks++; if (!(tv == 2 && th == 10)) begin errors++; $display("FAIL base_seek_timeout: got h=%0d v=%0d", th, tv); end
        base_addr = 16'h2345;
        n = 0;
        while (!(th == HT - 2 && tv == VT - 1) && n < HT * VT) begin
            checks++; if (mem_en !== exp_en(th, tv)) begin errors++; $display("FAIL base_old_en h=%0d v=%0d: got %b expected %b", th, tv, mem_en, exp_en(th, tv)); end
            if (exp_en(th, tv)) begin
                checks++; if (mem_addr !== exp_addr(th, tv, 16'h1000)) begin errors++; $display("FAIL base_old_addr h=%0d v=%0d: got %h expected %h", th, tv, mem_addr, exp_addr(th, tv, 16'h1000)); end
            end
            step();
            n++;
        end
        checks++; if (mem_en !== 1'b1 || mem_addr !== 16'h2345) begin errors++; $display("FAIL base_new_first: got en=%b addr=%h expected en=1 addr=2345", mem_en, mem_addr); end
        n = 0;
        while (!(tv == 0 && th == HA) && n < 2 * HT) begin
            if (tv == 0) begin
                checks++; if (pixel !== exp_pix(th, 0, 16'h2345)) begin errors++; $display("FAIL base_new_pixel h=%0d: got %b expected %b", th, pixel, exp_pix(th, 0, 16'h2345)); end
            end
            if (exp_en(th, tv)) begin
                checks++; if (mem_addr !== exp_addr(th, tv, 16'h2345)) begin errors++; $display("FAIL base_new_addr h=%0d v=%0d: got %h expected %h", th, tv, mem_addr, exp_addr(th, tv, 16'h2345)); end
            end
            step();
            n++;
        end
        checks++; if (!(tv == 0 && th == HA)) begin errors++; $display("FAIL base_line0_timeout: got h=%0d v=%0d", th, tv); end
    endtask

    task automatic test_reset_mid();
        int n = 0;
        apply_reset(16'h1000);
        while (!(tv == 4 && th == 20) && n < 6 * HT) begin step(); n++; end
        checks++; if (active !== 1'b1) begin errors++; $display("FAIL mid_active_before: got %b expected 1", active); end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++; if (mem_en !== 1'b1 || mem_addr !== 16'h1000) begin errors++; $display("FAIL mid_restart_fetch: got en=%b addr=%h expected en=1 addr=1000", mem_en, mem_addr); end
        checks++; if (active !== 1'b0 || pixel !== 1'b0) begin errors++; $display("FAIL mid_restart_blank: got active=%b pixel=%b expected 0 0", active, pixel); end
        checks++; if (hsync !== 1'b1 || vsync !== 1'b1) begin errors++; $display("FAIL mid_restart_sync: got h=%b v=%b expected 1 1", hsync, vsync); end
        n = 0;
        while (!(tv == 0 && th == HA) && n < 2 * HT) begin
            if (tv == 0) begin
                checks++; if (pixel !== exp_pix(th, 0, 16'h1000)) begin errors++; $display("FAIL mid_line0_pixel h=%0d: got %b expected %b", th, pixel, exp_pix(th, 0, 16'h1000)); end
            end
            checks++; if (mem_en !== exp_en(th, tv)) begin errors++; $display("FAIL mid_line0_en h=%0d v=%0d: got %b expected %b", th, tv, mem_en, exp_en(th, tv)); end
            step();
            n++;
        end
        checks++; if (!(tv == 0 && th == HA)) begin errors++; $display("FAIL mid_line0_timeout: got h=%0d v=%0d", th, tv); end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'(i);
        test_reset();
        test_raster();
`ifdef VIDEO_SCANDOUBLE_EN
        test_scandouble();
`else
        test_a5();
`endif
        test_wrap();
        test_base_change();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
